// File: rtl/vec_pkg.sv
// Shared types and default geometry for the vector execute unit.
// Lane opcodes, controller states and the default vector/lane/beat sizing.
package vec_pkg;

    localparam int VEC_VW  = 256;
    localparam int VEC_EW  = 8;
    localparam int VEC_LPC = 8;

    typedef enum logic [2:0] {
        VOP_ADD = 3'b000,
        VOP_SUB = 3'b001,
        VOP_AND = 3'b010,
        VOP_OR  = 3'b011,
        VOP_MUL = 3'b100,
        VOP_SRL = 3'b101,
        VOP_SLL = 3'b110,
        VOP_MOV = 3'b111
    } vop_e;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        BUSY = 2'b01,
        DONE = 2'b10
    } vstate_e;

endpackage

// File: rtl/vector_lane_alu.sv
// Single-lane combinational ALU; all results wrap modulo 2^EW.
// Shift amounts use only the low three bits of b.
module vector_lane_alu
    import vec_pkg::*;
#(
    parameter int EW = VEC_EW
) (
    input  logic [EW-1:0] a,
    input  logic [EW-1:0] b,
    input  vop_e          op,
    output logic [EW-1:0] y
);

    // Lane operation select
    always_comb begin
        y = a;
        case (op)
            VOP_ADD: y = a + b;
            VOP_SUB: y = a - b;
            VOP_AND: y = a & b;
            VOP_OR:  y = a | b;
            VOP_MUL: y = a * b;
            VOP_SRL: y = a >> b[2:0];
            VOP_SLL: y = a << b[2:0];
            VOP_MOV: y = a;
            default: y = a;
        endcase
    end

endmodule

// File: rtl/vector_execute.sv
// Multi-cycle vector execute unit: processes LPC lanes per beat, stalls the
// front end while busy and presents a registered result with a one-cycle valid.
module vector_execute
    import vec_pkg::*;
#(
    parameter int N   = 24,
    parameter int VW  = VEC_VW,
    parameter int EW  = VEC_EW,
    parameter int LPC = VEC_LPC
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          vRegWriteE,
    input  logic          vMemWriteE,
    input  logic [2:0]    ALUControlE,
    input  logic          ALUSrcE,
    input  logic [N-1:0]  ExtImmE,
    input  logic [3:0]    WA3E,
    input  logic [VW-1:0] vRD1E,
    input  logic [VW-1:0] vRD2E,
    output logic          StallV,
    output logic          vValidM,
    output logic [VW-1:0] vResultM,
    output logic          vRegWriteM,
    output logic          vMemWriteM,
    output logic [3:0]    WA3M
);

    localparam int LANES = VW / EW;
    localparam int SW    = EW * LPC;
    localparam int BEATS = VW / SW;
    localparam int CW    = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam logic [CW-1:0] LAST_BEAT = CW'(BEATS - 1);

    vstate_e       state_r;
    vstate_e       state_next_s;
    logic [CW-1:0] cnt_r;
    logic [VW-1:0] a_r;
    logic [VW-1:0] b_r;
    logic [VW-1:0] buf_r;
    vop_e          op_r;
    logic [3:0]    wa_r;
    logic          rw_r;
    logic          mw_r;

    logic          valid_m_r;
    logic [VW-1:0] result_m_r;
    logic          rw_m_r;
    logic          mw_m_r;
    logic [3:0]    wa_m_r;

    logic          start_s;
    logic          load_s;
    logic          stall_s;
    logic          last_beat_s;
    logic [VW-1:0] b_sel_s;
    logic [SW-1:0] a_slice_s;
    logic [SW-1:0] b_slice_s;
    logic [SW-1:0] y_slice_s;
    logic [VW-1:0] buf_next_s;
    logic          unused_imm_s;

    assign start_s      = vRegWriteE | vMemWriteE;
    assign last_beat_s  = (cnt_r == LAST_BEAT);
    assign b_sel_s      = ALUSrcE ? {LANES{ExtImmE[EW-1:0]}} : vRD2E;
    assign unused_imm_s = ^ExtImmE[N-1:EW];

    assign a_slice_s = a_r[cnt_r * SW +: SW];
    assign b_slice_s = b_r[cnt_r * SW +: SW];

    for (genvar g = 0; g < LPC; g++) begin : g_lane
        vector_lane_alu #(.EW(EW)) u_lane (
            .a  (a_slice_s[g*EW +: EW]),
            .b  (b_slice_s[g*EW +: EW]),
            .op (op_r),
            .y  (y_slice_s[g*EW +: EW])
        );
    end

    // Merge the current beat's lanes into the result buffer
    always_comb begin
        buf_next_s = buf_r;
        buf_next_s[cnt_r * SW +: SW] = y_slice_s;
    end

    // Controller state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Controller next-state logic
    always_comb begin
        state_next_s = IDLE;
        case (state_r)
            IDLE:    state_next_s = start_s ? BUSY : IDLE;
            BUSY:    state_next_s = last_beat_s ? DONE : BUSY;
            DONE:    state_next_s = start_s ? BUSY : IDLE;
            default: state_next_s = IDLE;
        endcase
    end

    // Controller outputs: stall releases in the last beat so DE advances once
    always_comb begin
        stall_s = 1'b0;
        load_s  = 1'b0;
        case (state_r)
            IDLE: begin
                stall_s = start_s;
                load_s  = start_s;
            end
            BUSY: begin
                stall_s = ~last_beat_s;
                load_s  = 1'b0;
            end
            DONE: begin
                stall_s = start_s;
                load_s  = start_s;
            end
            default: begin
                stall_s = 1'b0;
                load_s  = 1'b0;
            end
        endcase
    end

    // Operand latch, beat counter and result buffer
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_r <= '0;
            a_r   <= '0;
            b_r   <= '0;
            buf_r <= '0;
            op_r  <= VOP_ADD;
            wa_r  <= 4'd0;
            rw_r  <= 1'b0;
            mw_r  <= 1'b0;
        end else if (load_s) begin
            cnt_r <= '0;
            a_r   <= vRD1E;
            b_r   <= b_sel_s;
            op_r  <= vop_e'(ALUControlE);
            wa_r  <= WA3E;
            rw_r  <= vRegWriteE;
            mw_r  <= vMemWriteE;
        end else if (state_r == BUSY) begin
            cnt_r <= cnt_r + CW'(1);
            buf_r <= buf_next_s;
        end
    end

    // Memory-side outputs: captured at the last beat so they hold through DONE
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_m_r  <= 1'b0;
            result_m_r <= '0;
            rw_m_r     <= 1'b0;
            mw_m_r     <= 1'b0;
            wa_m_r     <= 4'd0;
        end else if ((state_r == BUSY) && last_beat_s) begin
            valid_m_r  <= 1'b1;
            result_m_r <= buf_next_s;
            rw_m_r     <= rw_r;
            mw_m_r     <= mw_r;
            wa_m_r     <= wa_r;
        end else begin
            valid_m_r  <= 1'b0;
            rw_m_r     <= 1'b0;
            mw_m_r     <= 1'b0;
        end
    end

    assign StallV     = stall_s;
    assign vValidM    = valid_m_r;
    assign vResultM   = result_m_r;
    assign vRegWriteM = rw_m_r;
    assign vMemWriteM = mw_m_r;
    assign WA3M       = wa_m_r;

endmodule

// File: tb/tb_vector_execute.sv
// Self-checking bench for vector_execute: directed and random vector ops
// compared against a whole-vector arithmetic reference model.
module tb_vector_execute;

    localparam int VW = 256;
    typedef logic [VW-1:0] vec_t;

    typedef struct {
        vec_t        a;
        vec_t        b;
        logic [2:0]  op;
        logic        src;
        logic [23:0] imm;
        logic [3:0]  wa;
        logic        rw;
        logic        mw;
    } op_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        vRegWriteE, vMemWriteE, vRegWriteE1, vMemWriteE1;
    logic [2:0]  ALUControlE;
    logic        ALUSrcE;
    logic [23:0] ExtImmE;
    logic [3:0]  WA3E;
    vec_t        vRD1E, vRD2E;
    logic        StallV, vValidM, vRegWriteM, vMemWriteM;
    vec_t        vResultM;
    logic [3:0]  WA3M;
    logic        StallV1, vValidM1, vRegWriteM1, vMemWriteM1;
    vec_t        vResultM1;
    logic [3:0]  WA3M1;

    int errors = 0;
    int checks = 0;
    op_t none_op;

    vector_execute dut (
        .clk(clk), .rst(rst), .vRegWriteE(vRegWriteE), .vMemWriteE(vMemWriteE),
        .ALUControlE(ALUControlE), .ALUSrcE(ALUSrcE), .ExtImmE(ExtImmE), .WA3E(WA3E),
        .vRD1E(vRD1E), .vRD2E(vRD2E), .StallV(StallV), .vValidM(vValidM),
        .vResultM(vResultM), .vRegWriteM(vRegWriteM), .vMemWriteM(vMemWriteM), .WA3M(WA3M)
    );

    vector_execute #(.LPC(32)) dut1 (
        .clk(clk), .rst(rst), .vRegWriteE(vRegWriteE1), .vMemWriteE(vMemWriteE1),
        .ALUControlE(ALUControlE), .ALUSrcE(ALUSrcE), .ExtImmE(ExtImmE), .WA3E(WA3E),
        .vRD1E(vRD1E), .vRD2E(vRD2E), .StallV(StallV1), .vValidM(vValidM1),
        .vResultM(vResultM1), .vRegWriteM(vRegWriteM1), .vMemWriteM(vMemWriteM1), .WA3M(WA3M1)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input vec_t obs, input vec_t exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic vec_t model(input op_t o);
        vec_t r;
        int ai, bi, y;
        r = '0;
        for (int k = 0; k < 32; k++) begin
            ai = int'(o.a[k*8 +: 8]);
            bi = o.src ? int'(o.imm[7:0]) : int'(o.b[k*8 +: 8]);
            case (o.op)
                3'd0:    y = (ai + bi) % 256;
                3'd1:    y = (ai - bi + 256) % 256;
                3'd2:    y = ai & bi;
                3'd3:    y = ai | bi;
                3'd4:    y = (ai * bi) % 256;
                3'd5:    y = ai / (1 << (bi % 8));
                3'd6:    y = (ai * (1 << (bi % 8))) % 256;
                default: y = ai;
            endcase
            r[k*8 +: 8] = y[7:0];
        end
        return r;
    endfunction

    function automatic vec_t rand_vec();
        vec_t r;
        for (int i = 0; i < 8; i++) r[i*32 +: 32] = $urandom();
        return r;
    endfunction

    function automatic vec_t fill(input logic [7:0] v);
        vec_t r;
        for (int k = 0; k < 32; k++) r[k*8 +: 8] = v;
        return r;
    endfunction

    task automatic drive(input op_t o);
        vRD1E = o.a; vRD2E = o.b; ALUControlE = o.op; ALUSrcE = o.src;
        ExtImmE = o.imm; WA3E = o.wa; vRegWriteE = o.rw; vMemWriteE = o.mw;
    endtask

    task automatic bubble();
        vRegWriteE = 1'b0;
        vMemWriteE = 1'b0;
    endtask

    // Runs one op as the DE register would present it: held while stalled,
    // replaced (by a bubble or the chained op) on the edge where stall is low.
    task automatic run_op(input string tag, input op_t o, input bit drive_it,
                          input bit chain, input op_t nxt);
        vec_t exp;
        int stalls, lat;
        bit advanced, st;
        exp = model(o);
        stalls = 0; lat = 0; advanced = 1'b0;
        if (drive_it) drive(o);
        for (int cyc = 0; cyc < 20; cyc++) begin
            #1;
            if (!advanced && StallV) stalls++;
            if (cyc > 0 && vValidM === 1'b1) begin
                lat = cyc;
                break;
            end
            st = StallV;
            @(posedge clk); #1;
            if (!advanced && !st) begin
                advanced = 1'b1;
                if (chain) drive(nxt);
                else bubble();
            end
        end
        chk({tag, "_stall_cycles"}, vec_t'(stalls), vec_t'(4));
        chk({tag, "_latency"}, vec_t'(lat), vec_t'(5));
        chk({tag, "_result"}, vResultM, exp);
        chk({tag, "_wa3m"}, vec_t'(WA3M), vec_t'(o.wa));
        chk({tag, "_regwrite"}, vec_t'(vRegWriteM), vec_t'(o.rw));
        chk({tag, "_memwrite"}, vec_t'(vMemWriteM), vec_t'(o.mw));
    endtask

    task automatic pulse_end(input string tag);
        @(posedge clk); #2;
        chk({tag, "_valid_low"}, vec_t'(vValidM), vec_t'(0));
        chk({tag, "_regwrite_low"}, vec_t'(vRegWriteM), vec_t'(0));
    endtask

    initial begin
        op_t o, o2;
        int pulses;
        vec_t lane_idx;

        none_op = '{a: '0, b: '0, op: 3'd0, src: 1'b0, imm: 24'd0, wa: 4'd0, rw: 1'b0, mw: 1'b0};
        rst = 1'b1;
        vRegWriteE1 = 1'b0; vMemWriteE1 = 1'b0;
        drive(none_op);
        repeat (2) @(posedge clk);
        #2;
        chk("reset_stall", vec_t'(StallV), vec_t'(0));
        chk("reset_valid", vec_t'(vValidM), vec_t'(0));
        chk("reset_result", vResultM, '0);
        chk("reset_wa3m", vec_t'(WA3M), vec_t'(0));
        chk("reset_flags", vec_t'({vRegWriteM, vMemWriteM}), vec_t'(0));
        chk("reset_result_lpc32", vResultM1, '0);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk); #1;

        // Add, register source
        o = '{a: fill(8'h10), b: fill(8'h05), op: 3'b000, src: 1'b0, imm: 24'd0,
              wa: 4'd3, rw: 1'b1, mw: 1'b0};
        run_op("add", o, 1'b1, 1'b0, none_op);
        chk("add_const", vResultM, fill(8'h15));
        pulse_end("add");

        // Wrap on add, then borrow on subtract
        o = '{a: fill(8'hF0), b: fill(8'h20), op: 3'b000, src: 1'b0, imm: 24'd0,
              wa: 4'd5, rw: 1'b1, mw: 1'b0};
        run_op("wrap", o, 1'b1, 1'b0, none_op);
        chk("wrap_const", vResultM, fill(8'h10));
        pulse_end("wrap");
        o = '{a: fill(8'h00), b: fill(8'h01), op: 3'b001, src: 1'b0, imm: 24'd0,
              wa: 4'd6, rw: 1'b0, mw: 1'b1};
        run_op("sub", o, 1'b1, 1'b0, none_op);
        chk("sub_const", vResultM, fill(8'hFF));
        pulse_end("sub");

        // Immediate broadcast and lane order
        for (int k = 0; k < 32; k++) lane_idx[k*8 +: 8] = 8'(k);
        o = '{a: lane_idx, b: rand_vec(), op: 3'b100, src: 1'b1, imm: 24'h000003,
              wa: 4'd7, rw: 1'b1, mw: 1'b0};
        run_op("imm_mul", o, 1'b1, 1'b0, none_op);
        chk("imm_lane31", vec_t'(vResultM[255:248]), vec_t'(8'h5D));
        chk("imm_lane1", vec_t'(vResultM[15:8]), vec_t'(8'h03));
        pulse_end("imm_mul");

        // Back-to-back: second op starts in the first op's DONE cycle
        o  = '{a: rand_vec(), b: rand_vec(), op: 3'b000, src: 1'b0, imm: 24'd0,
               wa: 4'd1, rw: 1'b1, mw: 1'b0};
        o2 = '{a: rand_vec(), b: rand_vec(), op: 3'b110, src: 1'b0, imm: 24'd0,
               wa: 4'd2, rw: 1'b0, mw: 1'b1};
        run_op("b2b_first", o, 1'b1, 1'b1, o2);
        run_op("b2b_second", o2, 1'b0, 1'b0, none_op);
        pulse_end("b2b");

        // Reset mid-op
        o = '{a: rand_vec(), b: rand_vec(), op: 3'b011, src: 1'b0, imm: 24'd0,
              wa: 4'd12, rw: 1'b1, mw: 1'b1};
        drive(o);
        repeat (2) begin
            @(posedge clk); #1;
        end
        rst = 1'b1;
        bubble();
        #1;
        chk("midrst_stall", vec_t'(StallV), vec_t'(0));
        chk("midrst_valid", vec_t'(vValidM), vec_t'(0));
        chk("midrst_result", vResultM, '0);
        chk("midrst_wa3m", vec_t'(WA3M), vec_t'(0));
        chk("midrst_flags", vec_t'({vRegWriteM, vMemWriteM}), vec_t'(0));
        @(negedge clk);
        rst = 1'b0;
        pulses = 0;
        repeat (8) begin
            @(posedge clk); #2;
            if (vValidM === 1'b1) pulses++;
        end
        chk("midrst_no_pulse", vec_t'(pulses), vec_t'(0));
        @(posedge clk); #1;
        o.wa = 4'd13;
        run_op("after_rst", o, 1'b1, 1'b0, none_op);
        pulse_end("after_rst");

        // Scalar op: no stall, no result
        o = '{a: rand_vec(), b: rand_vec(), op: 3'b000, src: 1'b0, imm: 24'd0,
              wa: 4'd4, rw: 1'b0, mw: 1'b0};
        drive(o);
        #1;
        chk("scalar_stall", vec_t'(StallV), vec_t'(0));
        pulses = 0;
        repeat (7) begin
            @(posedge clk); #2;
            if (vValidM === 1'b1) pulses++;
        end
        chk("scalar_no_pulse", vec_t'(pulses), vec_t'(0));
        @(posedge clk); #1;

        // Random ops
        for (int i = 0; i < 10; i++) begin
            o.a   = rand_vec();
            o.b   = rand_vec();
            o.op  = 3'($urandom_range(0, 7));
            o.src = 1'($urandom_range(0, 1));
            o.imm = 24'($urandom());
            o.wa  = 4'($urandom_range(0, 15));
            o.rw  = 1'($urandom_range(0, 1));
            o.mw  = o.rw ? 1'($urandom_range(0, 1)) : 1'b1;
            run_op($sformatf("rand%0d", i), o, 1'b1, 1'b0, none_op);
            pulse_end($sformatf("rand%0d", i));
        end

        // LPC=32 build: single beat, move op
        bubble();
        o = '{a: rand_vec(), b: rand_vec(), op: 3'b111, src: 1'b0, imm: 24'd0,
              wa: 4'd9, rw: 1'b1, mw: 1'b0};
        vRD1E = o.a; vRD2E = o.b; ALUControlE = o.op; ALUSrcE = 1'b0; WA3E = o.wa;
        vRegWriteE1 = 1'b1;
        #1;
        chk("lpc32_start_stall", vec_t'(StallV1), vec_t'(1));
        @(posedge clk); #2;
        chk("lpc32_busy_stall", vec_t'(StallV1), vec_t'(0));
        chk("lpc32_busy_valid", vec_t'(vValidM1), vec_t'(0));
        @(posedge clk); #1;
        vRegWriteE1 = 1'b0;
        #1;
        chk("lpc32_valid", vec_t'(vValidM1), vec_t'(1));
        chk("lpc32_result", vResultM1, model(o));
        chk("lpc32_result_is_a", vResultM1, o.a);
        chk("lpc32_wa3m", vec_t'(WA3M1), vec_t'(9));
        chk("lpc32_regwrite", vec_t'(vRegWriteM1), vec_t'(1));
        @(posedge clk); #2;
        chk("lpc32_valid_low", vec_t'(vValidM1), vec_t'(0));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
